// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: FSM states,
// opcodes, ALU operation codes and datapath select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's alu_op plus instruction fields
// onto the shared ALU's operation encoding.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  alu_op_t    alu_op,
  output logic [2:0] alu_control
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with funct7b5 subtracts; addi reuses op[5]=0 to always add.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multi-cycle RISC-V core: sequences each
// instruction and drives every datapath select and write enable.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic [3:0] state
);

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    pc_update, branch;
  logic    ir_write_s, mem_write_s, reg_write_s;

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_ITYPE:     state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:             state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:            state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = ALUWB;
      JAL:                state_d = ALUWB;
      default:            state_d = FETCH;
    endcase
  end

  always_comb begin
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REG;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: reg_write_s = 1'b1;
      BEQ: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst_n so FETCH's own enables stay quiet while in reset.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_s;
  assign mem_write = rst_n & mem_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign state     = state_q;

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (alu_op),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference
// model (state path, write enables, ALU op) driven by directed and random stimulus.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'h7f;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .reg_write(reg_write), .state(state)
  );

  // Reference: what an R/I ALU instruction asks of the ALU.
  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && o == RT && f7) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Starts and ends at a falling edge with the FSM in FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input bit force_z, input logic zval, input string tag);
    int seq[$];
    bit writes_rd;
    logic z, e_pcw, e_rw, e_mw;
    logic [2:0] e_alu;
    case (o)
      LW:      seq = '{0, 1, 2, 3, 4};
      SW:      seq = '{0, 1, 2, 5};
      RT:      seq = '{0, 1, 6, 8};
      IT:      seq = '{0, 1, 7, 8};
      BQ:      seq = '{0, 1, 9};
      JL:      seq = '{0, 1, 10, 8};
      default: seq = '{0, 1};
    endcase
    writes_rd = (o == LW) || (o == RT) || (o == IT) || (o == JL);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < seq.size(); i++) begin
      z = force_z ? zval : 1'($urandom_range(0, 1));
      zero = z;
      #1;
      e_pcw = (i == 0) || (o == JL && i == 2) || (o == BQ && i == 2 && z);
      e_rw  = writes_rd && (i == seq.size() - 1);
      e_mw  = (o == SW) && (i == seq.size() - 1);
      if ((o == RT || o == IT) && i == 2) e_alu = exp_alu(o, f3, f7);
      else if (o == BQ && i == 2)         e_alu = 3'b001;
      else                                e_alu = 3'b000;
      total++; if (state !== 4'(seq[i])) begin bad++; $display("FAIL %s step%0d state got=%0d exp=%0d", tag, i, state, seq[i]); end
      total++; if (pc_write !== e_pcw) begin bad++; $display("FAIL %s step%0d pc_write got=%b exp=%b", tag, i, pc_write, e_pcw); end
      total++; if (reg_write !== e_rw) begin bad++; $display("FAIL %s step%0d reg_write got=%b exp=%b", tag, i, reg_write, e_rw); end
      total++; if (mem_write !== e_mw) begin bad++; $display("FAIL %s step%0d mem_write got=%b exp=%b", tag, i, mem_write, e_mw); end
      total++; if (ir_write !== (i == 0)) begin bad++; $display("FAIL %s step%0d ir_write got=%b exp=%b", tag, i, ir_write, (i == 0)); end
      total++; if (alu_control !== e_alu) begin bad++; $display("FAIL %s step%0d alu_control got=%b exp=%b", tag, i, alu_control, e_alu); end
      total++; if (imm_src !== exp_imm(o)) begin bad++; $display("FAIL %s step%0d imm_src got=%b exp=%b", tag, i, imm_src, exp_imm(o)); end
      case (seq[i])
        0: begin
          total++; if ({adr_src, alu_src_a, alu_src_b, result_src} !== 7'b0_00_10_10) begin bad++; $display("FAIL %s fetch selects got=%b exp=0001010", tag, {adr_src, alu_src_a, alu_src_b, result_src}); end
        end
        2: begin
          total++; if ({alu_src_a, alu_src_b} !== 4'b10_01) begin bad++; $display("FAIL %s memadr a/b got=%b exp=1001", tag, {alu_src_a, alu_src_b}); end
        end
        3, 5: begin
          total++; if ({adr_src, result_src} !== 3'b1_00) begin bad++; $display("FAIL %s mem access adr/result got=%b exp=100", tag, {adr_src, result_src}); end
        end
        4: begin
          total++; if (result_src !== 2'b01) begin bad++; $display("FAIL %s memwb result_src got=%b exp=01", tag, result_src); end
        end
        10: begin
          total++; if ({alu_src_a, alu_src_b} !== 4'b01_10) begin bad++; $display("FAIL %s jal a/b got=%b exp=0110", tag, {alu_src_a, alu_src_b}); end
        end
        default: ;
      endcase
      @(posedge clk); @(negedge clk);
    end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL %s end state got=%0d exp=0", tag, state); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 7'h7f;
    for (int i = 0; i < 3; i++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++; if ({state, pc_write, ir_write, mem_write, reg_write} !== 8'h00) begin bad++; $display("FAIL reset hold got=%h exp=00", {state, pc_write, ir_write, mem_write, reg_write}); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (state !== 4'd1) begin bad++; $display("FAIL reset release state got=%0d exp=1", state); end
    @(posedge clk); @(negedge clk);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset nop state got=%0d exp=0", state); end
  endtask

  task automatic test_lw();
    run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, "lw");
  endtask

  task automatic test_alu();
    run_instr(RT, 3'b000, 1'b1, 1'b0, 1'b0, "sub");
    run_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0, "add");
    run_instr(IT, 3'b000, 1'b1, 1'b0, 1'b0, "addi");
    run_instr(RT, 3'b010, 1'b0, 1'b0, 1'b0, "slt");
    run_instr(RT, 3'b110, 1'b1, 1'b0, 1'b0, "or");
    run_instr(IT, 3'b111, 1'b0, 1'b0, 1'b0, "andi");
    run_instr(RT, 3'b100, 1'b1, 1'b0, 1'b0, "xor_as_add");
  endtask

  task automatic test_beq();
    run_instr(BQ, 3'b000, 1'b0, 1'b1, 1'b1, "beq_taken");
    run_instr(BQ, 3'b000, 1'b0, 1'b1, 1'b0, "beq_not_taken");
  endtask

  task automatic test_sw_jal();
    run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, "sw");
    run_instr(JL, 3'b000, 1'b0, 1'b0, 1'b0, "jal");
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, "illegal");
  endtask

  task automatic test_reset_mid();
    op = RT; funct3 = 3'b000; funct7b5 = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    total++; if (state !== 4'd6) begin bad++; $display("FAIL midreset executer state got=%0d exp=6", state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL midreset async state got=%0d exp=0", state); end
    total++; if ({reg_write, pc_write, ir_write} !== 3'b000) begin bad++; $display("FAIL midreset enables got=%b exp=000", {reg_write, pc_write, ir_write}); end
    @(posedge clk); #1;
    total++; if ({state, reg_write} !== 5'd0) begin bad++; $display("FAIL midreset held got=%h exp=00", {state, reg_write}); end
    @(negedge clk); rst_n = 1'b1;
    run_instr(IT, 3'b110, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [6:0] legal [6] = '{LW, SW, RT, IT, BQ, JL};
    logic [6:0] o;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do o = 7'($urandom); while (o inside {LW, SW, RT, IT, BQ, JL});
      end else begin
        o = legal[$urandom_range(0, 5)];
      end
      run_instr(o, 3'($urandom), 1'($urandom), 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu();
    test_beq();
    test_sw_jal();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
